// File: rtl/crap_pkg.sv
// Shared types and constants for the craps datapath front end.
//   roll_state_t : roll FSM states (IDLE, ROLLING, VALID)
//   DIE_MIN/MAX  : legal face range of one die
//   SUM_W        : width of the two-dice sum (2..12 fits in 4 bits)
//   die_sum()    : zero-extending adder for two die faces
package crap_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROLLING = 2'd1,
    VALID   = 2'd2
  } roll_state_t;

  localparam logic [2:0] DIE_MIN = 3'd1;
  localparam logic [2:0] DIE_MAX = 3'd6;
  localparam int         SUM_W   = 4;

  // Both operands are at most 6, so the 4-bit result never overflows.
  function automatic logic [SUM_W-1:0] die_sum(input logic [2:0] a, input logic [2:0] b);
    return SUM_W'(a) + SUM_W'(b);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability-counter debouncer for the roll button.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous active-low reset
//   btn    in  raw, asynchronous, bouncing button
//   btn_db out debounced button level
// btn_db only follows the synchronised button after DB_LIMIT consecutive
// cycles of disagreement; any shorter glitch restarts the count.
module btn_debounce #(
  parameter int DB_CNT_W = 16,
  parameter int DB_LIMIT = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic btn_db
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_LIMIT - 1);

  logic                btn_m;
  logic                btn_s;
  logic [DB_CNT_W-1:0] cnt;

  // Synchroniser stage: raw btn is only ever sampled here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      btn_m <= btn;
      btn_s <= btn_m;
    end
  end

  // Debounce stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      btn_db <= 1'b0;
    end else if (btn_s == btn_db) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      btn_db <= btn_s;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dice_roll_unit.sv
// Craps front end: debounced roll button, two free-running 1..6 dice
// counters, latch of both dice and their sum on button release, and a
// valid/ack handshake towards the game FSM.
// Ports:
//   clk        in  system clock
//   reset      in  asynchronous active-low reset
//   btn        in  raw roll button (1 = pressed)
//   roll_ack   in  result consumed (only honoured while roll_valid=1)
//   die1_q     out latched die 1 (0 before first roll)
//   die2_q     out latched die 2 (0 before first roll)
//   sum        out die1_q + die2_q (0 before first roll)
//   roll_valid out result valid, held until acked
//   rolling    out button debounced-pressed, dice spinning
module dice_roll_unit
  import crap_pkg::*;
#(
  parameter int DB_CNT_W = 16,
  parameter int DB_LIMIT = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn,
  input  logic             roll_ack,
  output logic [2:0]       die1_q,
  output logic [2:0]       die2_q,
  output logic [SUM_W-1:0] sum,
  output logic             roll_valid,
  output logic             rolling
);

  logic        btn_db;
  logic        btn_db_d;
  logic        rise;
  logic        fall;
  logic [2:0]  d1;
  logic [2:0]  d2;
  logic        latch;
  roll_state_t state;
  roll_state_t state_nxt;

  btn_debounce #(
    .DB_CNT_W (DB_CNT_W),
    .DB_LIMIT (DB_LIMIT)
  ) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .btn    (btn),
    .btn_db (btn_db)
  );

  // Edge detect stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) btn_db_d <= 1'b0;
    else        btn_db_d <= btn_db;
  end

  assign rise = btn_db & ~btn_db_d;
  assign fall = ~btn_db & btn_db_d;

  // Spin counter stage: d1 is the fast digit, d2 steps on each d1 wrap,
  // so every one of the 36 pairs appears once per 36 cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d1 <= DIE_MIN;
      d2 <= DIE_MIN;
    end else if (d1 == DIE_MAX) begin
      d1 <= DIE_MIN;
      d2 <= (d2 == DIE_MAX) ? DIE_MIN : d2 + 3'd1;
    end else begin
      d1 <= d1 + 3'd1;
    end
  end

  // FSM stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) state_nxt = ROLLING;
      end
      ROLLING: begin
        if (fall) begin
          latch     = 1'b1;
          state_nxt = VALID;
        end
      end
      VALID: begin
        // Being in VALID already guarantees one visible cycle of roll_valid
        // before a (possibly long-held) ack can take us back to IDLE.
        if (roll_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rolling    = (state == ROLLING);
  assign roll_valid = (state == VALID);

  // Result latch stage: values persist past the ack until the next roll.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      die1_q <= 3'd0;
      die2_q <= 3'd0;
      sum    <= '0;
    end else if (latch) begin
      die1_q <= d1;
      die2_q <= d2;
      sum    <= die_sum(d1, d2);
    end
  end

endmodule
